// File: rtl/ramwriter_pkg.sv
// Shared constants for the RAM write path: ramwriter state encodings and the
// burst lengths the control unit selects for each store-type opcode.
package ramwriter_pkg;

    // ramwriter FSM state encodings
    localparam logic [1:0] RW_IDLE = 2'd0;
    localparam logic [1:0] RW_WR   = 2'd1;
    localparam logic [1:0] RW_FIN  = 2'd2;

    // Opcode to len mapping (bytes to write minus one)
    localparam logic [2:0] LEN_PUSH   = 3'd7;
    localparam logic [2:0] LEN_MOVAR  = 3'd7;
    localparam logic [2:0] LEN_MOVAR4 = 3'd3;
    localparam logic [2:0] LEN_MOVAR1 = 3'd0;

endpackage

// File: rtl/ramwriter.sv
// Serialises a register or stack value into little-endian byte writes on the
// 8-bit data RAM port. d[7:0] lands at addr and higher bytes follow at rising
// addresses. kp holds the control unit while the burst runs, and done pulses
// one cycle after the last byte.
module ramwriter
    import ramwriter_pkg::*;
#(
    parameter int AW = 16,
    parameter int DW = 64
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [2:0]    len,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] d,
    output logic          we,
    output logic [AW-1:0] adq,
    output logic [7:0]    q,
    output logic          kp,
    output logic          done
);

    logic [1:0]    state;
    logic [2:0]    cnt;
    logic [2:0]    tim;
    logic [DW-1:0] sreg;
    logic [63:0]   data_ext;
    logic [2:0]    nxt_idx;
    logic [7:0]    nxt_byte;

    // Zero-extend the latched data so the byte mux works for narrower DW
    always_comb begin
        data_ext = '0;
        data_ext[DW-1:0] = sreg;
    end

    assign nxt_idx = cnt + 3'd1;

    // Select the byte to put on q next cycle; mirrors the read-side demux
    always_comb begin
        nxt_byte = 8'h00;
        case (nxt_idx)
            3'd0:    nxt_byte = data_ext[7:0];
            3'd1:    nxt_byte = data_ext[15:8];
            3'd2:    nxt_byte = data_ext[23:16];
            3'd3:    nxt_byte = data_ext[31:24];
            3'd4:    nxt_byte = data_ext[39:32];
            3'd5:    nxt_byte = data_ext[47:40];
            3'd6:    nxt_byte = data_ext[55:48];
            3'd7:    nxt_byte = data_ext[63:56];
            default: nxt_byte = 8'h00;
        endcase
    end

    // Burst FSM. adq also serves as the running address pointer, so an
    // address wrap past the top of memory falls out of the AW-bit adder.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= RW_IDLE;
            cnt   <= 3'd0;
            tim   <= 3'd0;
            sreg  <= '0;
            we    <= 1'b0;
            adq   <= '0;
            q     <= 8'h00;
            kp    <= 1'b0;
            done  <= 1'b0;
        end else begin
            case (state)
                RW_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        sreg  <= d;
                        tim   <= len;
                        cnt   <= 3'd0;
                        adq   <= addr;
                        q     <= d[7:0];
                        we    <= 1'b1;
                        kp    <= 1'b1;
                        state <= RW_WR;
                    end
                end
                RW_WR: begin
                    if (cnt == tim) begin
                        we    <= 1'b0;
                        kp    <= 1'b0;
                        done  <= 1'b1;
                        state <= RW_FIN;
                    end else begin
                        cnt <= nxt_idx;
                        adq <= adq + AW'(1);
                        q   <= nxt_byte;
                    end
                end
                RW_FIN: begin
                    done  <= 1'b0;
                    state <= RW_IDLE;
                end
                default: begin
                    we    <= 1'b0;
                    kp    <= 1'b0;
                    done  <= 1'b0;
                    state <= RW_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ramwriter.sv
// Directed self-checking bench for ramwriter: reset state, bursts of several
// lengths, address wrap, ignored starts while busy or in FIN, reset mid-burst
// and reset-over-start priority.
module tb_ramwriter;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [2:0]  len;
    logic [15:0] addr;
    logic [63:0] d;
    logic        we;
    logic [15:0] adq;
    logic [7:0]  q;
    logic        kp;
    logic        done;

    int   total = 0;
    int   bad = 0;
    int   wr_count = 0;
    logic hit_3000 = 1'b0;

    ramwriter #(.AW(16), .DW(64)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .len   (len),
        .addr  (addr),
        .d     (d),
        .we    (we),
        .adq   (adq),
        .q     (q),
        .kp    (kp),
        .done  (done)
    );

    // 100 MHz clock
    always #5 clk = ~clk;

    // Count RAM writes and watch for the forbidden address, sampled mid-cycle
    always @(negedge clk) begin
        if (we === 1'b1) begin
            wr_count++;
            if (adq == 16'h3000) hit_3000 = 1'b1;
        end
    end

    // Single comparison point: counts every check and reports mismatches
    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock and settle just after the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pulse start for one edge, then scramble the inputs to prove they are not reused
    task automatic applyStimulus(input logic [2:0] l, input logic [15:0] a, input logic [63:0] data);
        start = 1'b1;
        len   = l;
        addr  = a;
        d     = data;
        tick();
        start = 1'b0;
        len   = 3'd5;
        addr  = 16'hDEAD;
        d     = 64'hFFEE_DDCC_BBAA_9988;
    endtask

    // Run one burst and check every cycle; optionally inject a start at byte
    // busy_at or a reset during byte rst_at (-1 disables each)
    task automatic runBurst(input string tag, input logic [2:0] l, input logic [15:0] a,
                            input logic [63:0] data, input int busy_at, input int rst_at);
        logic [63:0] sh;
        logic [15:0] ea;
        wr_count = 0;
        hit_3000 = 1'b0;
        applyStimulus(l, a, data);
        for (int i = 0; i <= int'(l); i++) begin
            ea = a + 16'(i);
            sh = data >> (8 * i);
            checkOutput({tag, " we"},   64'(we),   64'd1);
            checkOutput({tag, " adq"},  64'(adq),  64'(ea));
            checkOutput({tag, " q"},    64'(q),    64'(sh[7:0]));
            checkOutput({tag, " kp"},   64'(kp),   64'd1);
            checkOutput({tag, " done"}, 64'(done), 64'd0);
            if (i == busy_at) begin
                start = 1'b1;
                len   = 3'd1;
                addr  = 16'h3000;
                d     = 64'h0000_0000_0000_EEEE;
            end
            if (i == rst_at) rst = 1'b1;
            tick();
            start = 1'b0;
            if (i == rst_at) begin
                rst = 1'b0;
                checkOutput({tag, " rst we"},   64'(we),   64'd0);
                checkOutput({tag, " rst kp"},   64'(kp),   64'd0);
                checkOutput({tag, " rst done"}, 64'(done), 64'd0);
                checkOutput({tag, " rst count"}, 64'(wr_count), 64'(rst_at + 1));
                return;
            end
        end
        ea = a + 16'(l);
        sh = data >> (8 * int'(l));
        checkOutput({tag, " fin done"}, 64'(done), 64'd1);
        checkOutput({tag, " fin we"},   64'(we),   64'd0);
        checkOutput({tag, " fin kp"},   64'(kp),   64'd0);
        checkOutput({tag, " hold adq"}, 64'(adq),  64'(ea));
        checkOutput({tag, " hold q"},   64'(q),    64'(sh[7:0]));
        tick();
        checkOutput({tag, " idle done"}, 64'(done), 64'd0);
        checkOutput({tag, " idle we"},   64'(we),   64'd0);
        checkOutput({tag, " count"},     64'(wr_count), 64'(int'(l) + 1));
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        len   = 3'd0;
        addr  = 16'h0000;
        d     = 64'h0;
        tick();
        tick();
        rst = 1'b0;
        repeat (5) tick();
        checkOutput("reset we",   64'(we),   64'd0);
        checkOutput("reset kp",   64'(kp),   64'd0);
        checkOutput("reset done", 64'(done), 64'd0);
        checkOutput("reset adq",  64'(adq),  64'd0);
        checkOutput("reset q",    64'(q),    64'd0);

        runBurst("b8",   3'd7, 16'h0100, 64'h8877_6655_4433_2211, -1, -1);
        runBurst("b1",   3'd0, 16'h2000, 64'h0000_0000_0000_00AB, -1, -1);
        runBurst("b2",   3'd1, 16'h2100, 64'h0000_0000_0000_1234, -1, -1);
        runBurst("wrap", 3'd3, 16'hFFFE, 64'h0000_0000_DDCC_BBAA, -1, -1);
        runBurst("busy", 3'd7, 16'h4000, 64'h0807_0605_0403_0201, 2, -1);
        checkOutput("busy hit3000", 64'(hit_3000), 64'd0);
        runBurst("rst",  3'd7, 16'h0200, 64'h1122_3344_5566_7788, -1, 2);
        runBurst("after", 3'd7, 16'h0300, 64'hA1B2_C3D4_E5F6_0718, -1, -1);

        // A start held during the done cycle must not launch a burst
        applyStimulus(3'd0, 16'h5000, 64'h77);
        checkOutput("fin1 q", 64'(q), 64'h77);
        tick();
        checkOutput("fin1 done", 64'(done), 64'd1);
        start = 1'b1;
        len   = 3'd0;
        addr  = 16'h6000;
        tick();
        start = 1'b0;
        checkOutput("finstart we", 64'(we), 64'd0);
        tick();
        checkOutput("finstart we2", 64'(we), 64'd0);
        checkOutput("finstart kp",  64'(kp), 64'd0);

        // Reset wins over start on the same edge
        rst   = 1'b1;
        start = 1'b1;
        addr  = 16'h7000;
        tick();
        rst   = 1'b0;
        start = 1'b0;
        checkOutput("prio we", 64'(we), 64'd0);
        checkOutput("prio kp", 64'(kp), 64'd0);
        tick();
        checkOutput("prio we2", 64'(we), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
